// File: rtl/video_timing.sv
// video_timing: 640x480@60 Hz raster generator with a 256x240 game window,
// pixel-doubled 2x in both axes. All outputs are registered and decoded from
// the counter state being loaded, so every output refers to the (h,v) that
// the counters hold in the same cycle.
module video_timing #(
  parameter int H_OFFSET = 64,
  parameter int V_OFFSET = 0
) (
  input  logic       gpu_clk,
  input  logic       rst,
  output logic [7:0] current_x,
  output logic [7:0] current_y,
  output logic [8:0] next_x,
  output logic [8:0] next_y,
  output logic       hsync,
  output logic       vsync,
  output logic       visible,
  output logic       in_window,
  output logic       frame_start,
  output logic       vblank_start
);

  // Raster geometry (800 x 525 total, 640 x 480 active).
  localparam logic [9:0] H_LAST      = 10'd799;
  localparam logic [9:0] H_VIS_END   = 10'd640;
  localparam logic [9:0] H_SYNC_BEG  = 10'd656;
  localparam logic [9:0] H_SYNC_END  = 10'd752;
  localparam logic [9:0] V_LAST      = 10'd524;
  localparam logic [9:0] V_VIS_END   = 10'd480;
  localparam logic [9:0] V_SYNC_BEG  = 10'd490;
  localparam logic [9:0] V_SYNC_END  = 10'd492;

  // Game window bounds; the upper bounds are exclusive and carry an extra
  // bit so an offset near the end of the raster cannot wrap the compare.
  localparam logic [10:0] H_WIN_BEG   = 11'(H_OFFSET);
  localparam logic [10:0] H_WIN_END   = 11'(H_OFFSET + 512);
  localparam logic [10:0] V_WIN_BEG   = 11'(V_OFFSET);
  localparam logic [10:0] V_WIN_END   = 11'(V_OFFSET + 480);
  localparam logic [9:0]  H_WIN_BEG10 = 10'(H_OFFSET);
  localparam logic [9:0]  V_WIN_BEG10 = 10'(V_OFFSET);

  // Counter state, its next value, and the value one step beyond that
  // (needed because next_* describe the position after the one being loaded).
  logic [9:0] h_q, v_q;
  logic [9:0] h_d, v_d;
  logic [9:0] h_dd, v_dd;

  logic       hsync_q, vsync_q, visible_q, in_window_q;
  logic       frame_start_q, vblank_start_q;
  logic [7:0] current_x_q, current_y_q;
  logic [8:0] next_x_q, next_y_q;

  // One raster step: h wraps at 799 and carries into v, which wraps at 524.
  function automatic logic [19:0] advance(input logic [9:0] h, input logic [9:0] v);
    if (h == H_LAST) begin
      return {10'd0, (v == V_LAST) ? 10'd0 : v + 10'd1};
    end
    return {h + 10'd1, v};
  endfunction

  function automatic logic h_in_win(input logic [9:0] h);
    return ({1'b0, h} >= H_WIN_BEG) && ({1'b0, h} < H_WIN_END);
  endfunction

  function automatic logic v_in_win(input logic [9:0] v);
    return ({1'b0, v} >= V_WIN_BEG) && ({1'b0, v} < V_WIN_END);
  endfunction

  // Game coordinate is bits [8:1] of the offset-relative raster position;
  // forced to 0 when the axis lies outside the window.
  function automatic logic [7:0] game_x(input logic [9:0] h);
    return h_in_win(h) ? 8'((h - H_WIN_BEG10) >> 1) : 8'd0;
  endfunction

  function automatic logic [7:0] game_y(input logic [9:0] v);
    return v_in_win(v) ? 8'((v - V_WIN_BEG10) >> 1) : 8'd0;
  endfunction

  // Prefetch encoding: bit 8 flags an out-of-window axis.
  function automatic logic [8:0] prefetch_x(input logic [9:0] h);
    return h_in_win(h) ? {1'b0, game_x(h)} : 9'h100;
  endfunction

  function automatic logic [8:0] prefetch_y(input logic [9:0] v);
    return v_in_win(v) ? {1'b0, game_y(v)} : 9'h100;
  endfunction

  assign {h_d, v_d}   = advance(h_q, v_q);
  assign {h_dd, v_dd} = advance(h_d, v_d);

  // Counters and every output flop; outputs decode the position being loaded.
  always_ff @(posedge gpu_clk) begin
    // NOTE: all state uses non-blocking assignments so every flop samples the
    // pre-edge values; reset is synchronous, so it lives inside this block.
    if (rst) begin
      h_q            <= 10'd0;
      v_q            <= 10'd0;
      hsync_q        <= 1'b1;
      vsync_q        <= 1'b1;
      visible_q      <= 1'b1;
      in_window_q    <= h_in_win(10'd0) && v_in_win(10'd0);
      current_x_q    <= game_x(10'd0);
      current_y_q    <= game_y(10'd0);
      next_x_q       <= prefetch_x(10'd1);
      next_y_q       <= prefetch_y(10'd0);
      frame_start_q  <= 1'b0;
      vblank_start_q <= 1'b0;
    end else begin
      h_q            <= h_d;
      v_q            <= v_d;
      hsync_q        <= !((h_d >= H_SYNC_BEG) && (h_d < H_SYNC_END));
      vsync_q        <= !((v_d >= V_SYNC_BEG) && (v_d < V_SYNC_END));
      visible_q      <= (h_d < H_VIS_END) && (v_d < V_VIS_END);
      in_window_q    <= (h_d < H_VIS_END) && (v_d < V_VIS_END)
                        && h_in_win(h_d) && v_in_win(v_d);
      current_x_q    <= game_x(h_d);
      current_y_q    <= game_y(v_d);
      next_x_q       <= prefetch_x(h_dd);
      next_y_q       <= prefetch_y(v_dd);
      frame_start_q  <= (h_d == 10'd0) && (v_d == 10'd0);
      vblank_start_q <= (h_d == 10'd0) && (v_d == V_VIS_END);
    end
  end

  assign current_x    = current_x_q;
  assign current_y    = current_y_q;
  assign next_x       = next_x_q;
  assign next_y       = next_y_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign visible      = visible_q;
  assign in_window    = in_window_q;
  assign frame_start  = frame_start_q;
  assign vblank_start = vblank_start_q;

endmodule

// File: tb/tb_video_timing.sv
// Testbench for video_timing: directed raster positions with hand-computed
// expected outputs, a mid-frame reset sequence, and per-line/per-frame
// counters for sync widths and strobe placement.
module tb_video_timing;

  logic       gpu_clk = 1'b0;
  logic       rst     = 1'b1;
  logic [7:0] current_x, current_y;
  logic [8:0] next_x, next_y;
  logic       hsync, vsync, visible, in_window, frame_start, vblank_start;

  video_timing dut (
    .gpu_clk      (gpu_clk),
    .rst          (rst),
    .current_x    (current_x),
    .current_y    (current_y),
    .next_x       (next_x),
    .next_y       (next_y),
    .hsync        (hsync),
    .vsync        (vsync),
    .visible      (visible),
    .in_window    (in_window),
    .frame_start  (frame_start),
    .vblank_start (vblank_start)
  );

  always #5 gpu_clk = ~gpu_clk;

  // Output vector layout: {hsync, vsync, visible, in_window, cx, cy, nx, ny, fs, vb}
  typedef struct {
    int          h;
    int          v;
    logic [39:0] exp;
  } vec_t;

  int     n_checks  = 0;
  int     n_fail    = 0;
  int     mh        = 0;
  int     mv        = 0;
  longint cycle     = 0;
  longint ref_cycle = 0;
  int     hs_low    = 0;
  int     vs_low    = 0;
  int     fs_count  = 0;
  int     vbs_count = 0;

  vec_t vec_a[19];
  vec_t vec_b[12];
  logic [39:0] rst_exp;

  function automatic logic [39:0] mk(input logic hs, input logic vs, input logic vis,
                                      input logic inw, input logic [7:0] cx,
                                      input logic [7:0] cy, input logic [8:0] nx,
                                      input logic [8:0] ny, input logic fs, input logic vb);
    return {hs, vs, vis, inw, cx, cy, nx, ny, fs, vb};
  endfunction

  function automatic vec_t mkv(input int h, input int v, input logic [39:0] e);
    vec_t r;
    r.h = h;
    r.v = v;
    r.exp = e;
    return r;
  endfunction

  function automatic logic [39:0] actual();
    return {hsync, vsync, visible, in_window, current_x, current_y,
            next_x, next_y, frame_start, vblank_start};
  endfunction

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock: update the reference position, then sample on the falling edge.
  task automatic tick();
    @(posedge gpu_clk);
    if (rst) begin
      mh = 0;
      mv = 0;
    end else if (mh == 799) begin
      mh = 0;
      mv = (mv == 524) ? 0 : mv + 1;
    end else begin
      mh++;
    end
    cycle++;
    @(negedge gpu_clk);
    if (mh == 0) hs_low = 0;
    if (hsync !== 1'b1) hs_low++;
    if (mh == 799) check($sformatf("hsync_low_cycles_v%0d", mv), 40'(hs_low), 40'd96);
    if (mh == 0 && mv == 0) vs_low = 0;
    if (vsync !== 1'b1) vs_low++;
    if (mh == 799 && mv == 524) check("vsync_low_cycles_frame", 40'(vs_low), 40'd1600);
    if (frame_start === 1'b1) begin
      fs_count++;
      check("frame_start_position", 40'(mh * 1024 + mv), 40'd0);
      check("frame_start_period", 40'(cycle - ref_cycle), 40'd420000);
    end
    if (vblank_start === 1'b1) begin
      vbs_count++;
      check("vblank_start_position", 40'(mh * 1024 + mv), 40'(480));
    end
  endtask

  task automatic run_to(input int h, input int v);
    int budget;
    budget = 0;
    while (!(mh == h && mv == v) && budget < 450000) begin
      tick();
      budget++;
    end
    if (!(mh == h && mv == v)) begin
      n_checks++;
      n_fail++;
      $display("FAIL run_to_h%0d_v%0d: position not reached, at h=%0d v=%0d", h, v, mh, mv);
    end
  endtask

  task automatic apply(input vec_t t, input string tag);
    run_to(t.h, t.v);
    check($sformatf("%s_h%0d_v%0d", tag, t.h, t.v), actual(), t.exp);
  endtask

  initial begin
    rst_exp = mk(1, 1, 1, 0, 8'd0, 8'd0, 9'h100, 9'h000, 0, 0);

    // Frame after reset release: line 0 window edges, line timing, row stepping.
    vec_a[0]  = mkv(1,   0,   mk(1, 1, 1, 0, 8'd0,   8'd0,   9'h100, 9'h000, 0, 0));
    vec_a[1]  = mkv(62,  0,   mk(1, 1, 1, 0, 8'd0,   8'd0,   9'h100, 9'h000, 0, 0));
    vec_a[2]  = mkv(63,  0,   mk(1, 1, 1, 0, 8'd0,   8'd0,   9'h000, 9'h000, 0, 0));
    vec_a[3]  = mkv(64,  0,   mk(1, 1, 1, 1, 8'd0,   8'd0,   9'h000, 9'h000, 0, 0));
    vec_a[4]  = mkv(65,  0,   mk(1, 1, 1, 1, 8'd0,   8'd0,   9'h001, 9'h000, 0, 0));
    vec_a[5]  = mkv(66,  0,   mk(1, 1, 1, 1, 8'd1,   8'd0,   9'h001, 9'h000, 0, 0));
    vec_a[6]  = mkv(575, 0,   mk(1, 1, 1, 1, 8'd255, 8'd0,   9'h100, 9'h000, 0, 0));
    vec_a[7]  = mkv(576, 0,   mk(1, 1, 1, 0, 8'd0,   8'd0,   9'h100, 9'h000, 0, 0));
    vec_a[8]  = mkv(639, 0,   mk(1, 1, 1, 0, 8'd0,   8'd0,   9'h100, 9'h000, 0, 0));
    vec_a[9]  = mkv(640, 0,   mk(1, 1, 0, 0, 8'd0,   8'd0,   9'h100, 9'h000, 0, 0));
    vec_a[10] = mkv(655, 0,   mk(1, 1, 0, 0, 8'd0,   8'd0,   9'h100, 9'h000, 0, 0));
    vec_a[11] = mkv(656, 0,   mk(0, 1, 0, 0, 8'd0,   8'd0,   9'h100, 9'h000, 0, 0));
    vec_a[12] = mkv(751, 0,   mk(0, 1, 0, 0, 8'd0,   8'd0,   9'h100, 9'h000, 0, 0));
    vec_a[13] = mkv(752, 0,   mk(1, 1, 0, 0, 8'd0,   8'd0,   9'h100, 9'h000, 0, 0));
    vec_a[14] = mkv(799, 0,   mk(1, 1, 0, 0, 8'd0,   8'd0,   9'h100, 9'h000, 0, 0));
    vec_a[15] = mkv(799, 1,   mk(1, 1, 0, 0, 8'd0,   8'd0,   9'h100, 9'h001, 0, 0));
    vec_a[16] = mkv(0,   2,   mk(1, 1, 1, 0, 8'd0,   8'd1,   9'h100, 9'h001, 0, 0));
    vec_a[17] = mkv(100, 199, mk(1, 1, 1, 1, 8'd18,  8'd99,  9'h012, 9'h063, 0, 0));
    vec_a[18] = mkv(300, 200, mk(1, 1, 1, 1, 8'd118, 8'd100, 9'h076, 9'h064, 0, 0));

    // Full frame after the mid-frame reset: bottom rows, vblank, vsync, wrap.
    vec_b[0]  = mkv(500, 479, mk(1, 1, 1, 1, 8'd218, 8'd239, 9'h0DA, 9'h0EF, 0, 0));
    vec_b[1]  = mkv(799, 479, mk(1, 1, 0, 0, 8'd0,   8'd239, 9'h100, 9'h100, 0, 0));
    vec_b[2]  = mkv(0,   480, mk(1, 1, 0, 0, 8'd0,   8'd0,   9'h100, 9'h100, 0, 1));
    vec_b[3]  = mkv(1,   480, mk(1, 1, 0, 0, 8'd0,   8'd0,   9'h100, 9'h100, 0, 0));
    vec_b[4]  = mkv(799, 489, mk(1, 1, 0, 0, 8'd0,   8'd0,   9'h100, 9'h100, 0, 0));
    vec_b[5]  = mkv(0,   490, mk(1, 0, 0, 0, 8'd0,   8'd0,   9'h100, 9'h100, 0, 0));
    vec_b[6]  = mkv(799, 491, mk(1, 0, 0, 0, 8'd0,   8'd0,   9'h100, 9'h100, 0, 0));
    vec_b[7]  = mkv(0,   492, mk(1, 1, 0, 0, 8'd0,   8'd0,   9'h100, 9'h100, 0, 0));
    vec_b[8]  = mkv(798, 524, mk(1, 1, 0, 0, 8'd0,   8'd0,   9'h100, 9'h100, 0, 0));
    vec_b[9]  = mkv(799, 524, mk(1, 1, 0, 0, 8'd0,   8'd0,   9'h100, 9'h000, 0, 0));
    vec_b[10] = mkv(0,   0,   mk(1, 1, 1, 0, 8'd0,   8'd0,   9'h100, 9'h000, 1, 0));
    vec_b[11] = mkv(1,   0,   mk(1, 1, 1, 0, 8'd0,   8'd0,   9'h100, 9'h000, 0, 0));

    // Reset held for three cycles, then released.
    rst = 1'b1;
    repeat (3) tick();
    check("reset_state", actual(), rst_exp);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) apply(vec_a[i], "frame0");

    // Mid-frame reset at (300,200) for one cycle: back to (0,0), no strobe.
    rst = 1'b1;
    tick();
    ref_cycle = cycle;
    check("midframe_reset_state", actual(), rst_exp);
    rst = 1'b0;
    tick();
    check("midframe_reset_release_h1", actual(),
          mk(1, 1, 1, 0, 8'd0, 8'd0, 9'h100, 9'h000, 0, 0));

    for (int i = 0; i < 12; i++) apply(vec_b[i], "frame1");

    check("frame_start_count", 40'(fs_count), 40'd1);
    check("vblank_start_count", 40'(vbs_count), 40'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
